// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard scoreboard.
//   opc_e    : op-class encoding driven by the decoder (3 is reserved and is
//              treated as ALU)
//   REG_AW   : register-index width
//   DEF_*    : default latency constants (bubbles owed to a dependent op)
//   lat_of() : bubbles owed for a given op class
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      OPC_ALU  = 2'd0,
      OPC_LOAD = 2'd1,
      OPC_MUL  = 2'd2
   } opc_e;

   localparam int unsigned REG_AW       = 5;
   localparam int unsigned DEF_NUM_REGS = 32;
   localparam int unsigned DEF_LOAD_LAT = 1;
   localparam int unsigned DEF_MUL_LAT  = 3;

   function automatic int unsigned lat_of(input logic [1:0] opc,
                                          input int unsigned load_lat,
                                          input int unsigned mul_lat);
      int unsigned lat;
      case (opc)
         OPC_LOAD: lat = load_lat;
         OPC_MUL:  lat = mul_lat;
         default:  lat = 0;
      endcase
      return lat;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// ID-stage instruction descriptor plus the stall/issue response.
//   master : ID stage (drives the instruction fields and flush_i)
//   slave  : hazard_scoreboard (drives stall_o / issue_o)
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if;
   import hazard_pkg::*;

   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic              id_use_rs1_i;
   logic              id_use_rs2_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_regwr_i;
   logic [1:0]        id_opc_i;
   logic              flush_i;
   logic              stall_o;
   logic              issue_o;

   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             id_rd_i, id_regwr_i, id_opc_i, flush_i,
      input  stall_o, issue_o
   );

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             id_rd_i, id_regwr_i, id_opc_i, flush_i,
      output stall_o, issue_o
   );

endinterface

// File: rtl/hazard_scoreboard_lat_counter.sv
// -----------------------------------------------------------------------------
// hazard_lat_counter
// Per-register down-counter of bubbles still owed to a consumer.
//   clk_i, rst_i : clock, synchronous active-low reset
//   i_set        : newest writer issued this cycle (wins over decrement)
//   i_set_val    : latency of that writer
//   o_cnt        : bubbles still owed
//   o_busy       : o_cnt != 0
// Saturates at zero; never wraps.
// -----------------------------------------------------------------------------
module hazard_lat_counter #(
   parameter int unsigned CW = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          i_set,
   input  logic [CW-1:0] i_set_val,
   output logic [CW-1:0] o_cnt,
   output logic          o_busy
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_i)
         r_cnt <= '0;
      else if (i_set)
         r_cnt <= i_set_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_cnt  = r_cnt;
   assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Issue-side RAW-hazard tracker: records each in-flight register writer and
// its remaining latency, and stalls the ID instruction until every source it
// reads is forwardable.
//   clk_i       : clock
//   rst_i       : synchronous reset, active-low
//   id_bus      : ID instruction descriptor in, stall_o / issue_o out
//   stall_cnt_o : stall-cycle counter, built only when HAZARD_PERF_EN is
//                 defined (saturating); otherwise tied to zero
// -----------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
   parameter int unsigned MUL_LAT  = DEF_MUL_LAT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   hazard_scoreboard_if.slave    id_bus,
   output logic [31:0]           stall_cnt_o
);

   localparam int unsigned CW = $clog2(MUL_LAT + 1);

   logic [CW-1:0] w_cnt  [NUM_REGS];
   logic          w_busy [NUM_REGS];
   logic [CW-1:0] w_set_val;
   logic          w_rec;
   logic          w_src1_haz;
   logic          w_src2_haz;
   logic          w_live;
   logic          w_stall;
   logic          w_issue;

   // x0 is hard-wired: never busy, so a source of x0 never stalls
   assign w_cnt[0]  = '0;
   assign w_busy[0] = 1'b0;

   assign w_set_val = CW'(lat_of(id_bus.id_opc_i, LOAD_LAT, MUL_LAT));
   assign w_rec     = w_issue & id_bus.id_regwr_i;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      hazard_lat_counter #(.CW(CW)) u_cnt (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .i_set     (w_rec && (id_bus.id_rd_i == REG_AW'(g))),
         .i_set_val (w_set_val),
         .o_cnt     (w_cnt[g]),
         .o_busy    (w_busy[g])
      );

      a_no_wrap: assert property (@(posedge clk_i) w_cnt[g] <= CW'(MUL_LAT));
   end

   assign w_src1_haz = id_bus.id_use_rs1_i & w_busy[id_bus.id_rs1_i];
   assign w_src2_haz = id_bus.id_use_rs2_i & w_busy[id_bus.id_rs2_i];
   assign w_live     = id_bus.id_valid_i & ~id_bus.flush_i;
   assign w_stall    = w_live & (w_src1_haz | w_src2_haz);
   assign w_issue    = w_live & ~w_stall;

   assign id_bus.stall_o = w_stall;
   assign id_bus.issue_o = w_issue;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_i)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   localparam int unsigned LLAT = 1;
   localparam int unsigned MLAT = 3;

   logic        clk;
   logic        rst_n;
   logic [31:0] stall_cnt;
   int          n_tests;
   int          n_fail;

   // Reference model: the cycle number from which each register is forwardable
   longint      ready [32];
   longint      now;
   longint      exp_cnt;

   hazard_scoreboard_if bus ();

   hazard_scoreboard #(
      .NUM_REGS (32),
      .LOAD_LAT (LLAT),
      .MUL_LAT  (MLAT)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .id_bus      (bus),
      .stall_cnt_o (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, now);
      end
   endtask

   function automatic longint bubbles(input logic [1:0] opc);
      if (opc == 2'd1) return longint'(LLAT);
      if (opc == 2'd2) return longint'(MLAT);
      return 0;
   endfunction

   function automatic bit src_hazard(input logic use_r, input logic [4:0] r);
      return use_r && (r != 5'd0) && (ready[r] > now);
   endfunction

   // One clock cycle: drive, check combinational outputs, advance the model
   task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic [1:0] opc, input logic fl,
                       input logic rn, output logic st, output logic is);
      bit es, ei;
      @(negedge clk);
      bus.id_valid_i   = v;
      bus.id_rs1_i     = rs1;
      bus.id_rs2_i     = rs2;
      bus.id_use_rs1_i = u1;
      bus.id_use_rs2_i = u2;
      bus.id_rd_i      = rd;
      bus.id_regwr_i   = wr;
      bus.id_opc_i     = opc;
      bus.flush_i      = fl;
      rst_n            = rn;
      #1;
      es = v && !fl && (src_hazard(u1, rs1) || src_hazard(u2, rs2));
      ei = v && !fl && !es;
      chk("stall_o", 32'(bus.stall_o), 32'(es));
      chk("issue_o", 32'(bus.issue_o), 32'(ei));
      chk("stall_cnt_o", stall_cnt, exp_cnt[31:0]);
      st = bus.stall_o;
      is = bus.issue_o;
      @(posedge clk);
      if (!rn) begin
         foreach (ready[i]) ready[i] = 0;
         exp_cnt = 0;
      end else begin
         if (ei && wr && rd != 5'd0) ready[rd] = now + 1 + bubbles(opc);
`ifdef HAZARD_PERF_EN
         if (es && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
`endif
      end
      now++;
   endtask

   task automatic idle(input logic rn);
      logic s, i;
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, rn, s, i);
   endtask

   // Producer with no sources: always issues
   task automatic produce(input logic [4:0] rd, input logic [1:0] opc);
      logic s, i;
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, opc, 1'b0, 1'b1, s, i);
   endtask

   // Hold a consumer in ID until it issues; returns the stall count
   task automatic consume(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, output int stalls);
      logic s, i;
      stalls = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 2'd0, 1'b0, 1'b1, s, i);
         if (i) break;
         stalls++;
      end
   endtask

   initial begin
      int  n;
      logic s, i;
      n_tests = 0;
      n_fail  = 0;
      now     = 0;
      exp_cnt = 0;
      foreach (ready[k]) ready[k] = 0;

      // Reset state
      idle(1'b0);
      idle(1'b0);
      idle(1'b1);

      // 1: load then dependent add -> one bubble, then no residue
      produce(5'd5, 2'd1);
      consume(5'd5, 5'd1, 5'd6, n);
      chk("t1_load_stalls", n, 1);
      consume(5'd5, 5'd5, 5'd11, n);
      chk("t1_cnt5_zero", n, 0);

      // 2: ALU back-to-back -> forwarding covers it
      produce(5'd7, 2'd0);
      consume(5'd7, 5'd0, 5'd12, n);
      chk("t2_alu_stalls", n, 0);

      // 3: MUL dependency -> MUL_LAT bubbles
      produce(5'd8, 2'd2);
      consume(5'd1, 5'd8, 5'd13, n);
      chk("t3_mul_stalls", n, MLAT);

      // 4: WAW, newer load replaces older MUL latency
      produce(5'd9, 2'd2);
      produce(5'd9, 2'd1);
      consume(5'd9, 5'd2, 5'd14, n);
      chk("t4_waw_stalls", n, 1);

      // 5: x0 never recorded; flush squashes the consumer
      produce(5'd0, 2'd1);
      consume(5'd0, 5'd0, 5'd15, n);
      chk("t5_x0_stalls", n, 0);
      produce(5'd3, 2'd1);
      step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd16, 1'b1, 2'd0, 1'b1, 1'b1, s, i);
      chk("t5_flush_stall", 32'(s), 0);
      chk("t5_flush_issue", 32'(i), 0);

      // 6: reset mid-stall releases the stall next cycle
      produce(5'd10, 2'd2);
      step(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 2'd0, 1'b0, 1'b1, s, i);
      chk("t6_pre_stall", 32'(s), 1);
      step(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 2'd0, 1'b0, 1'b0, s, i);
      step(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 2'd0, 1'b0, 1'b1, s, i);
      chk("t6_post_stall", 32'(s), 0);
      chk("t6_post_issue", 32'(i), 1);
      idle(1'b1);

      // Randomized traffic over a small register window to provoke hazards
      for (int k = 0; k < 3000; k++) begin
         step(logic'($urandom_range(0, 7) != 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), logic'($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), logic'($urandom_range(0, 15) == 0),
              logic'($urandom_range(0, 199) != 0), s, i);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
